// File: rtl/cr_mean_align.sv
// Pairs buffered raw Cr samples with late-arriving mean-Cr results and emits
// saturated centred chroma plus a per-pixel skin flag.
module cr_mean_align #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned ADDR_W      = 6,
  parameter logic [23:0] SKIN_THRESH = 24'd5120
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        cr,
  input  logic              cr_valid,
  input  logic [23:0]       mean_cr,
  input  logic              mean_cr_valid,
  input  logic              err_clr,
  output logic [15:0]       cr_diff,
  output logic [7:0]        cr_out,
  output logic              skin,
  output logic              out_valid,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned LVL_W  = ADDR_W + 1;
  localparam int unsigned DIFF_W = 25;

  logic [7:0]               mem [DEPTH];
  logic [ADDR_W-1:0]        wr_ptr;
  logic [ADDR_W-1:0]        rd_ptr;

  logic                     full_c;
  logic                     empty_c;
  logic                     pop_c;
  logic                     push_c;
  logic [7:0]               cr_head_c;
  logic signed [DIFF_W-1:0] d1_next_c;

  logic signed [DIFF_W-1:0] d1;
  logic [7:0]               cr1;
  logic                     v1;
  logic [DIFF_W-1:0]        abs_d1_c;
  logic [15:0]              sat_c;
  logic                     skin_c;

  // Full/empty are judged on the level at the start of the cycle; no bypass.
  always_comb begin
    full_c    = (fifo_level == LVL_W'(DEPTH));
    empty_c   = (fifo_level == '0);
    pop_c     = mean_cr_valid && !empty_c;
    push_c    = cr_valid && (!full_c || pop_c);
    cr_head_c = mem[rd_ptr];
    d1_next_c = DIFF_W'({1'b0, cr_head_c, 8'h00}) - DIFF_W'({1'b0, mean_cr});
  end

  // Storage array carries no reset; only pointers and level define contents.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= cr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push_c, pop_c})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky errors: a new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (cr_valid && !push_c)       overflow <= 1'b1;
      else if (err_clr)              overflow <= 1'b0;
      if (mean_cr_valid && empty_c)  underflow <= 1'b1;
      else if (err_clr)              underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1  <= '0;
      cr1 <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= pop_c;
      if (pop_c) begin
        d1  <= d1_next_c;
        cr1 <= cr_head_c;
      end
    end
  end

  always_comb begin
    abs_d1_c = d1[DIFF_W-1] ? DIFF_W'(-d1) : DIFF_W'(d1);
    skin_c   = (abs_d1_c <= DIFF_W'(SKIN_THRESH));
    if (d1 > 25'sd32767) begin
      sat_c = 16'h7FFF;
    end else if (d1 < -25'sd32768) begin
      sat_c = 16'h8000;
    end else begin
      sat_c = d1[15:0];
    end
  end

  // Result registers hold their last value while out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_diff   <= '0;
      cr_out    <= '0;
      skin      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        cr_diff <= sat_c;
        cr_out  <= cr1;
        skin    <= skin_c;
      end
    end
  end

endmodule

// File: tb/tb_cr_mean_align.sv
// Directed bench for cr_mean_align: scoreboard queue filled at stimulus time,
// drained by a monitor whenever out_valid is seen.
module tb_cr_mean_align;

  typedef struct packed {
    logic [15:0] diff;
    logic [7:0]  c;
    logic        s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cr;
  logic        cr_valid;
  logic [23:0] mean_cr;
  logic        mean_cr_valid;
  logic        err_clr;
  logic [15:0] cr_diff;
  logic [7:0]  cr_out;
  logic        skin;
  logic        out_valid;
  logic [6:0]  fifo_level;
  logic        overflow;
  logic        underflow;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  cr_mean_align dut (
    .clk(clk), .rst_n(rst_n), .cr(cr), .cr_valid(cr_valid),
    .mean_cr(mean_cr), .mean_cr_valid(mean_cr_valid), .err_clr(err_clr),
    .cr_diff(cr_diff), .cr_out(cr_out), .skin(skin), .out_valid(out_valid),
    .fifo_level(fifo_level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, let the edge take them, return #1 after the edge.
  task automatic cyc(input logic cv, input logic [7:0] c, input logic mv,
                     input logic [23:0] m, input logic ec = 1'b0);
    cr_valid = cv; cr = c; mean_cr_valid = mv; mean_cr = m; err_clr = ec;
    @(posedge clk);
    #1;
    cr_valid = 1'b0; mean_cr_valid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 1'b0, 24'd0);
  endtask

  task automatic expect_out(input logic [15:0] d, input logic [7:0] c, input logic s);
    exp_t e;
    e.diff = d; e.c = c; e.s = s;
    sb.push_back(e);
  endtask

  // Monitor: every presented result must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got diff=%h cr=%0d skin=%b, none expected",
                 cr_diff, cr_out, skin);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({cr_diff, cr_out, skin} !== e) begin
          n_err++;
          $display("FAIL out_data: got diff=%h cr=%0d skin=%b expected diff=%h cr=%0d skin=%b",
                   cr_diff, cr_out, skin, e.diff, e.c, e.s);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; cr = '0; cr_valid = 1'b0; mean_cr = '0; mean_cr_valid = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cr_diff", 32'(cr_diff), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_flags", 32'({overflow, underflow}), 32'd0);
    rst_n = 1'b1;

    // Basic pair with a 3-cycle gap, latency check
    cyc(1'b1, 8'd150, 1'b0, 24'd0);
    idle(2);
    expect_out(16'hFC00, 8'd150, 1'b1);
    cyc(1'b0, 8'd0, 1'b1, 24'd39424);
    chk("lat_v_after_1", 32'(out_valid), 32'd0);
    idle(1);
    chk("lat_v_after_2", 32'(out_valid), 32'd1);
    idle(1);
    chk("lat_v_drop", 32'(out_valid), 32'd0);

    cyc(1'b1, 8'd200, 1'b0, 24'd0);
    expect_out(16'h2E00, 8'd200, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 24'd39424);

    cyc(1'b1, 8'd255, 1'b0, 24'd0);
    expect_out(16'h7FFF, 8'd255, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 24'd0);
    cyc(1'b1, 8'd0, 1'b0, 24'd0);
    expect_out(16'h8000, 8'd0, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 24'hFFFFFF);

    // Skin threshold edge: |diff| = 20.0 passes, 20.0+1lsb fails
    cyc(1'b1, 8'd100, 1'b0, 24'd0);
    cyc(1'b1, 8'd100, 1'b0, 24'd0);
    expect_out(16'h1400, 8'd100, 1'b1);
    cyc(1'b0, 8'd0, 1'b1, 24'd20480);
    expect_out(16'h1401, 8'd100, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 24'd20479);
    idle(3);
    chk("held_diff", 32'(cr_diff), 32'h1401);
    chk("level_zero_a", 32'(fifo_level), 32'd0);

    // Fill to full plus one dropped sample
    for (int i = 0; i < 65; i++) cyc(1'b1, 8'(i * 3), 1'b0, 24'd0);
    chk("full_level", 32'(fifo_level), 32'd64);
    chk("overflow_set", 32'(overflow), 32'd1);
    cyc(1'b0, 8'd0, 1'b0, 24'd0, 1'b1);
    chk("overflow_clr", 32'(overflow), 32'd0);
    // Push while full is accepted when a pop happens in the same cycle
    expect_out(16'h0000, 8'd0, 1'b1);
    cyc(1'b1, 8'd250, 1'b1, 24'd0);
    chk("full_pushpop_level", 32'(fifo_level), 32'd64);
    chk("full_pushpop_noovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 64; i++) begin
      expect_out(16'h0000, 8'(i * 3), 1'b1);
      cyc(1'b0, 8'd0, 1'b1, 24'(i * 3 * 256));
    end
    expect_out(16'h0000, 8'd250, 1'b1);
    cyc(1'b0, 8'd0, 1'b1, 24'd64000);
    idle(3);
    chk("drain_level", 32'(fifo_level), 32'd0);

    // Underflow: pop on empty, even alongside the first push
    cyc(1'b1, 8'd42, 1'b1, 24'd1234);
    chk("uf_set", 32'(underflow), 32'd1);
    chk("uf_level", 32'(fifo_level), 32'd1);
    idle(3);
    cyc(1'b0, 8'd0, 1'b0, 24'd0, 1'b1);
    chk("uf_clr", 32'(underflow), 32'd0);
    expect_out(16'h0000, 8'd42, 1'b1);
    cyc(1'b0, 8'd0, 1'b1, 24'd10752);
    idle(3);
    cyc(1'b0, 8'd0, 1'b1, 24'd0, 1'b1);
    chk("uf_set_wins", 32'(underflow), 32'd1);
    cyc(1'b0, 8'd0, 1'b0, 24'd0, 1'b1);
    chk("uf_clr2", 32'(underflow), 32'd0);

    // Reset mid-stream with level 10 and two results in flight
    for (int i = 0; i < 12; i++) cyc(1'b1, 8'(10 + i), 1'b0, 24'd0);
    expect_out(16'h0000, 8'd10, 1'b1);
    cyc(1'b0, 8'd0, 1'b1, 24'd2560);
    cyc(1'b0, 8'd0, 1'b1, 24'd2816);
    chk("pre_rst_level", 32'(fifo_level), 32'd10);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_cr_diff", 32'(cr_diff), 32'd0);
    chk("arst_cr_out", 32'(cr_out), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 8'd77, 1'b0, 24'd0);
    expect_out(16'hFF00, 8'd77, 1'b1);
    cyc(1'b0, 8'd0, 1'b1, 24'd19968);
    idle(4);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("final_level", 32'(fifo_level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
